// File: rtl/snn_pkg.sv
// snn_pkg -- shared types and constants for the spiking-network blocks.
//   RATE_W / COUNT_W : widths of the stimulus rate and the spike count
//   enc_state_t      : spike_rate_encoder FSM states
//   LFSR_SEED / LFSR_TAPS : reset value and feedback mask of lfsr8
//                           (taps x^8+x^6+x^5+x^4+1 -> bits 7,5,4,3)
package snn_pkg;

    localparam int RATE_W  = 8;
    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        REPORT = 2'd2
    } enc_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hB8;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/spike_rate_encoder_lfsr8.sv
// lfsr8 -- 8-bit Fibonacci LFSR, advances every clock.
// Provides the per-window starting phase for the encoder when
// SPIKE_ENC_DITHER_EN is defined.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, loads LFSR_SEED
//   q     : current LFSR value (never zero)
module lfsr8
    import snn_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            // Feedback is the XOR of the tapped bits, shifted in at the LSB.
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder -- rate-codes an 8-bit stimulus into a spike train
// over a window of WINDOW encode cycles using a phase accumulator, then
// reports how many spikes it emitted.
//
// Optional feature macro: SPIKE_ENC_DITHER_EN. When defined, an lfsr8
// supplies the starting phase of each window instead of zero.
//
// Parameters:
//   WINDOW  : encode cycles per window, 1..255
//   REFRACT : silent cycles forced after each spike, 0..15
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   in_valid/in_ready/in_data : stimulus input handshake
//   spike_out    : registered one-cycle spike pulse
//   busy         : high whenever the FSM is not IDLE
//   spike_count  : spikes of the last completed window
//   count_valid  : one-cycle strobe qualifying spike_count
//   state_dbg    : current FSM state, for observation only
//
// Handshake: a value transfers on any rising edge where in_valid and
// in_ready are both high. in_ready depends on state only (high in IDLE),
// never on in_valid; the producer holds in_data until the transfer.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int WINDOW  = 255,
    parameter int REFRACT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RATE_W-1:0]  in_data,
    output logic               spike_out,
    output logic               busy,
    output logic [COUNT_W-1:0] spike_count,
    output logic               count_valid,
    output enc_state_t         state_dbg
);

    localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);
    localparam logic [3:0] REFR_LEN = 4'(REFRACT);

    enc_state_t          state, next_state;
    logic [RATE_W-1:0]   acc;
    logic [RATE_W-1:0]   rate;
    logic [7:0]          win_cnt;
    logic [3:0]          refr_cnt;
    logic [COUNT_W-1:0]  cnt;
    logic [RATE_W:0]     sum;
    logic [RATE_W-1:0]   acc_init;
    logic                accept;

`ifdef SPIKE_ENC_DITHER_EN
    logic [7:0] lfsr_q;

    lfsr8 u_lfsr8 (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign acc_init = lfsr_q;
`else
    assign acc_init = '0;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    // The carry out of the phase add is the spike condition.
    assign sum = {1'b0, acc} + {1'b0, rate};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ENCODE;
            ENCODE:  if (win_cnt == WIN_LAST) next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            rate        <= '0;
            win_cnt     <= '0;
            refr_cnt    <= '0;
            cnt         <= '0;
            spike_out   <= 1'b0;
            spike_count <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            case (state)
                IDLE: begin
                    spike_out <= 1'b0;
                    if (accept) begin
                        rate     <= in_data;
                        acc      <= acc_init;
                        win_cnt  <= '0;
                        cnt      <= '0;
                        refr_cnt <= '0;
                    end
                end
                ENCODE: begin
                    win_cnt <= win_cnt + 8'd1;
                    if (refr_cnt != 4'd0) begin
                        // Refractory: phase is frozen, no spike.
                        refr_cnt  <= refr_cnt - 4'd1;
                        spike_out <= 1'b0;
                    end else if (sum[RATE_W]) begin
                        spike_out <= 1'b1;
                        acc       <= sum[RATE_W-1:0];
                        cnt       <= cnt + 8'd1;
                        refr_cnt  <= REFR_LEN;
                    end else begin
                        acc       <= sum[RATE_W-1:0];
                        spike_out <= 1'b0;
                    end
                end
                REPORT: begin
                    // cnt already includes a spike from the last ENCODE cycle.
                    spike_count <= cnt;
                    count_valid <= 1'b1;
                    spike_out   <= 1'b0;
                end
                default: begin
                    spike_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;
  import snn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Three instances: (255,0), (255,3), (17,2)
  logic       valid_a   [3];
  logic       ready_a   [3];
  logic [7:0] data_a    [3];
  logic       spike_a   [3];
  logic       busy_a    [3];
  logic [7:0] count_a   [3];
  logic       cvalid_a  [3];
  enc_state_t state_a   [3];

  spike_rate_encoder #(.WINDOW(255), .REFRACT(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(valid_a[0]), .in_ready(ready_a[0]),
    .in_data(data_a[0]), .spike_out(spike_a[0]), .busy(busy_a[0]),
    .spike_count(count_a[0]), .count_valid(cvalid_a[0]), .state_dbg(state_a[0]));

  spike_rate_encoder #(.WINDOW(255), .REFRACT(3)) dut1 (
    .clk(clk), .reset(reset), .in_valid(valid_a[1]), .in_ready(ready_a[1]),
    .in_data(data_a[1]), .spike_out(spike_a[1]), .busy(busy_a[1]),
    .spike_count(count_a[1]), .count_valid(cvalid_a[1]), .state_dbg(state_a[1]));

  spike_rate_encoder #(.WINDOW(17), .REFRACT(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(valid_a[2]), .in_ready(ready_a[2]),
    .in_data(data_a[2]), .spike_out(spike_a[2]), .busy(busy_a[2]),
    .spike_count(count_a[2]), .count_valid(cvalid_a[2]), .state_dbg(state_a[2]));

  function automatic int win_of(input int i);
    case (i)
      0: return 255;
      1: return 255;
      default: return 17;
    endcase
  endfunction

  function automatic int refr_of(input int i);
    case (i)
      0: return 0;
      1: return 3;
      default: return 2;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];   // expected spike edges (1..WINDOW) of the current window

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: walk the window one encode cycle at a time with an
  // integer phase; a spike happens whenever the phase reaches 256, after
  // which REFRACT cycles are skipped. Fills exp_q, returns the spike count.
  function automatic int model(input int rate, input int w, input int r, input int acc0);
    int phase = acc0;
    int hold = 0;
    int n = 0;
    for (int k = 1; k <= w; k++) begin
      if (hold > 0) hold--;
      else begin
        phase += rate;
        if (phase >= 256) begin
          phase -= 256;
          n++;
          exp_q.push_back(9'(k));
          hold = r;
        end
      end
    end
    return n;
  endfunction

  // ---------------- driver ----------------
  // Offers rate to instance i, runs it through a whole window and the
  // report cycle. Returns at #1 after the report edge (count_valid high).
  task automatic run_window(input int i, input int rate, input bit hold,
                            output int got_count, output int first_edge);
    int w, r, exp_count, guard;
    bit exp_spk;
    w = win_of(i);
    r = refr_of(i);
    exp_q.delete();
    exp_count = model(rate, w, r, 0);
    valid_a[i] = 1'b1;
    data_a[i]  = 8'(rate);
    guard = 0;
    while (!ready_a[i] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check($sformatf("ready_before_accept[%0d]", i), int'(ready_a[i]), 1);
    @(posedge clk); #1;   // E0
    if (!hold) valid_a[i] = 1'b0;
    check($sformatf("busy_after_accept[%0d]", i), int'(busy_a[i]), 1);
    check($sformatf("cvalid_dropped[%0d]", i), int'(cvalid_a[i]), 0);
    first_edge = -1;
    for (int k = 1; k <= w + 1; k++) begin
      if (hold) data_a[i] = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      if (k <= w) begin
        if (spike_a[i] && first_edge < 0) first_edge = k;
`ifndef SPIKE_ENC_DITHER_EN
        exp_spk = (exp_q.size() > 0 && int'(exp_q[0]) == k);
        if (exp_spk) void'(exp_q.pop_front());
        check($sformatf("spike[%0d]@E%0d", i, k), int'(spike_a[i]), int'(exp_spk));
`endif
        check($sformatf("ready_low[%0d]@E%0d", i, k), int'(ready_a[i]), 0);
        check($sformatf("cvalid_low[%0d]@E%0d", i, k), int'(cvalid_a[i]), 0);
      end else begin
        check($sformatf("cvalid_strobe[%0d]", i), int'(cvalid_a[i]), 1);
        check($sformatf("ready_after_report[%0d]", i), int'(ready_a[i]), 1);
        check($sformatf("spike_idle[%0d]", i), int'(spike_a[i]), 0);
`ifndef SPIKE_ENC_DITHER_EN
        check($sformatf("spike_count[%0d] rate=%0d", i, rate), int'(count_a[i]), exp_count);
`endif
      end
    end
    valid_a[i] = 1'b0;
    got_count = int'(count_a[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int c, fe, seen;
    int fe_list[$];
    for (int i = 0; i < 3; i++) begin
      valid_a[i] = 1'b0;
      data_a[i]  = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_spike", int'(spike_a[0]), 0);
    check("rst_count", int'(count_a[0]), 0);
    check("rst_cvalid", int'(cvalid_a[0]), 0);
    check("rst_ready", int'(ready_a[0]), 1);
    check("rst_busy", int'(busy_a[0]), 0);
    check("rst_state", int'(state_a[0]), int'(IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

`ifndef SPIKE_ENC_DITHER_EN
    run_window(0, 0, 1'b0, c, fe);
    check("rate0_count", c, 0);
    check("rate0_no_spike", fe, -1);
    @(posedge clk); #1;

    run_window(0, 128, 1'b0, c, fe);
    check("rate128_count", c, 127);
    check("rate128_first_edge", fe, 2);

    // Back-to-back: next offer is taken at E_WINDOW+2
    run_window(0, 255, 1'b0, c, fe);
    check("rate255_count", c, 254);
    run_window(0, 1, 1'b0, c, fe);
    check("rate1_count", c, 0);

    run_window(1, 255, 1'b0, c, fe);
    check("refr3_count", c, 64);
    check("refr3_first_edge", fe, 2);

    // in_valid held high with changing data during ENCODE
    run_window(0, 77, 1'b1, c, fe);
    check("hold_count", c, (255 * 77) / 256);

    // Random rates against the model
    for (int n = 0; n < 3; n++) run_window(0, $urandom_range(0, 255), 1'b0, c, fe);
    for (int n = 0; n < 2; n++) run_window(1, $urandom_range(0, 255), 1'b0, c, fe);
    for (int n = 0; n < 24; n++) run_window(2, $urandom_range(0, 255), n[0], c, fe);
`else
    // Dithered start phase: count is floor or floor+1, phase moves around.
    for (int n = 0; n < 8; n++) begin
      run_window(0, 128, 1'b0, c, fe);
      check("dither_count_in_range", int'(c == 127 || c == 128), 1);
      fe_list.push_back(fe);
    end
    seen = 0;
    foreach (fe_list[j]) if (fe_list[j] != fe_list[0]) seen = 1;
    check("dither_phase_varies", seen, 1);
`endif

    // Reset in the middle of a window
    @(posedge clk); #1;
    valid_a[0] = 1'b1;
    data_a[0]  = 8'd200;
    @(posedge clk); #1;
    valid_a[0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("mid_busy_before_reset", int'(busy_a[0]), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_state", int'(state_a[0]), int'(IDLE));
    check("midrst_ready", int'(ready_a[0]), 1);
    check("midrst_busy", int'(busy_a[0]), 0);
    check("midrst_spike", int'(spike_a[0]), 0);
    check("midrst_count", int'(count_a[0]), 0);
    check("midrst_cvalid", int'(cvalid_a[0]), 0);
    seen = 0;
    for (int k = 0; k < 260; k++) begin
      @(posedge clk); #1;
      if (cvalid_a[0] || spike_a[0] || busy_a[0]) seen = 1;
    end
    check("midrst_quiet", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
